// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, ALU op encoding and sequencer states shared by alu_packet_ctrl.
package alu_ctrl_pkg;
   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hA0;
   localparam logic [7:0] OP_MUL  = 8'hA1;
   localparam logic [7:0] OP_DIV  = 8'hA2;
   localparam int HDR_BYTES = 4;
   typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_MUL = 2'd1, ALU_DIV = 2'd2} alu_op_t;
   typedef enum logic [3:0] {
      IDLE, HDR_RSV, HDR_LSB, HDR_MSB, ECHO, OPND, ALU_REQ, ALU_WAIT, DRAIN, RESP
   } ctrl_state_t;
endpackage

// File: rtl/alu_ctrl_resp_ser.sv
// alu_ctrl_resp_ser: loads up to 64 bits with a byte count and emits them LSB-first on a valid/ready byte stream.
module alu_ctrl_resp_ser (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [63:0] data_i,
   input  logic [3:0]  cnt_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        last_o
);
   logic [63:0] sr;
   logic [3:0]  cnt;
   assign tx_data_o  = sr[7:0];
   assign tx_valid_o = cnt != 4'd0;
   assign last_o     = tx_valid_o && tx_ready_i && cnt == 4'd1;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load_i) begin
         sr  <= data_i;
         cnt <= cnt_i;
      end else if (tx_valid_o && tx_ready_i) begin
         sr  <= sr >> 8;
         cnt <= cnt - 4'd1;
      end
   end
endmodule

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: parses host packets, sequences 32-bit ALU ops and returns results over the byte stream.
// Optional ALU_CTRL_TIMEOUT_EN aborts a stalled partial packet after TIMEOUT_CYCLES idle cycles.
module alu_packet_ctrl #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [1:0]  alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic        alu_valid_o,
   input  logic        alu_ready_i,
   input  logic        alu_done_i,
   input  logic [63:0] alu_result_i,
   output logic        busy_o,
   output logic [7:0]  err_count_o
);
   import alu_ctrl_pkg::*;
   ctrl_state_t state, nxt;
   logic [7:0]  opc, len_lo, echo_d, err_q, ser_d;
   logic [15:0] rem, len, pay;
   logic [1:0]  bi, nop, alu_op_q;
   logic [31:0] opnd, full;
   logic [63:0] acc;
   logic rdy_q, echo_v, resp_ld, rx_hs, is_math, is_div, op_done, need_alu, err_inc, timeout;
   logic ser_v, ser_last;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   // Echo accepts only while payload remains so the next header waits for IDLE.
   assign rx_ready_o  = state == ECHO ? rem != 16'd0 && (!echo_v || tx_ready_i) : rdy_q;
   assign rx_hs       = rx_valid_i && rx_ready_o;
   assign is_div      = opc == OP_DIV;
   assign is_math     = opc == OP_ADD || opc == OP_MUL || is_div;
   assign len         = {rx_data_i, len_lo};
   assign pay         = len < 16'(HDR_BYTES) ? 16'd0 : len - 16'(HDR_BYTES);
   assign full        = {rx_data_i, opnd[31:8]};
   assign op_done     = bi == 2'd3;
   assign need_alu    = op_done && nop != 2'd0 && !(is_div && nop == 2'd2);
   assign tx_valid_o  = echo_v || ser_v;
   assign tx_data_o   = echo_v ? echo_d : ser_d;
   assign alu_valid_o = state == ALU_REQ;
   assign alu_op_o    = alu_op_q;
   assign alu_a_o     = is_div ? acc[63:32] : acc[31:0];
   assign alu_b_o     = opnd;
   assign busy_o      = state != IDLE;
   assign err_count_o = err_q;

`ifdef ALU_CTRL_TIMEOUT_EN
   logic [31:0] tcnt;
   logic        tcount;
   assign tcount  = state inside {HDR_RSV, HDR_LSB, HDR_MSB, OPND, DRAIN, ECHO};
   assign timeout = tcount && !rx_hs && tcnt == 32'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tcnt <= '0;
      else tcnt <= (rx_hs || !tcount || timeout) ? 32'd0 : tcnt + 32'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      nxt     = state;
      err_inc = 1'b0;
      case (state)
         IDLE:     if (rx_hs) nxt = HDR_RSV;
         HDR_RSV:  if (rx_hs) nxt = HDR_LSB;
         HDR_LSB:  if (rx_hs) nxt = HDR_MSB;
         HDR_MSB:  if (rx_hs) begin
            err_inc = opc != OP_ECHO && !is_math;
            if (pay == 16'd0) nxt = is_math ? RESP : IDLE;
            else if (opc == OP_ECHO) nxt = ECHO;
            else nxt = is_math ? OPND : DRAIN;
         end
         ECHO:     if (echo_v && tx_ready_i && rem == 16'd0) nxt = IDLE;
         OPND:     if (rx_hs) nxt = need_alu ? ALU_REQ : rem == 16'd1 ? RESP : OPND;
         ALU_REQ:  if (alu_ready_i) nxt = ALU_WAIT;
         ALU_WAIT: if (alu_done_i) nxt = rem == 16'd0 ? RESP : OPND;
         DRAIN:    if (rx_hs && rem == 16'd1) nxt = IDLE;
         RESP:     if (ser_last) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
      if (timeout) begin
         nxt     = IDLE;
         err_inc = 1'b1;
      end
   end

   // DIV keeps {remainder, quotient}; the low word starts as all-ones so a missing divisor reads back as 0xFFFFFFFF.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         rdy_q    <= 1'b0;
         resp_ld  <= 1'b0;
         err_q    <= '0;
         echo_v   <= 1'b0;
         echo_d   <= '0;
         opc      <= '0;
         len_lo   <= '0;
         rem      <= '0;
         bi       <= '0;
         nop      <= '0;
         opnd     <= '0;
         acc      <= '0;
         alu_op_q <= '0;
      end else begin
         state   <= nxt;
         rdy_q   <= nxt inside {IDLE, HDR_RSV, HDR_LSB, HDR_MSB, OPND, DRAIN};
         resp_ld <= state == RESP;
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
         if ((echo_v && tx_ready_i) || timeout) echo_v <= 1'b0;
         if (rx_hs) begin
            case (state)
               IDLE:    opc <= rx_data_i;
               HDR_LSB: len_lo <= rx_data_i;
               HDR_MSB: begin
                  rem <= pay;
                  bi  <= '0;
                  nop <= '0;
                  acc <= is_div && pay != 16'd0 ? {32'd0, 32'hFFFF_FFFF} : 64'd0;
                  if (is_math) alu_op_q <= opc[1:0];
               end
               ECHO: begin
                  echo_d <= rx_data_i;
                  echo_v <= 1'b1;
                  rem    <= rem - 16'd1;
               end
               OPND: begin
                  rem  <= rem - 16'd1;
                  bi   <= bi + 2'd1;
                  opnd <= full;
                  if (op_done && nop == 2'd0) acc <= is_div ? {full, 32'hFFFF_FFFF} : {32'd0, full};
                  if (op_done && nop != 2'd2) nop <= nop + 2'd1;
               end
               DRAIN:   rem <= rem - 16'd1;
               default: ;
            endcase
         end
         if (state == ALU_WAIT && alu_done_i) acc <= is_div ? alu_result_i : {32'd0, alu_result_i[31:0]};
      end
   end

   alu_ctrl_resp_ser u_ser (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (state == RESP && !resp_ld),
      .data_i     (acc),
      .cnt_i      (is_div ? 4'd8 : 4'd4),
      .tx_data_o  (ser_d),
      .tx_valid_o (ser_v),
      .tx_ready_i (tx_ready_i),
      .last_o     (ser_last)
   );
endmodule

// File: tb/tb_alu_packet_ctrl.sv
// tb_alu_packet_ctrl: directed packets with hand-computed responses against alu_packet_ctrl and a behavioural ALU.
module tb_alu_packet_ctrl;
   logic        clk_i, rst_i;
   logic [7:0]  rx_data_i, tx_data_o, err_count_o;
   logic        rx_valid_i, rx_ready_o, tx_valid_o, tx_ready_i;
   logic [1:0]  alu_op_o;
   logic [31:0] alu_a_o, alu_b_o;
   logic        alu_valid_o, alu_ready_i, alu_done_i, busy_o;
   logic [63:0] alu_result_i;
   int          n_asr = 0, n_fail = 0;
   int          tx_base = 0;
   logic [7:0]  txq[$];
   logic [65:0] reqs[$];

   alu_packet_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_done_i(alu_done_i),
      .alu_result_i(alu_result_i), .busy_o(busy_o), .err_count_o(err_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);

   // Behavioural ALU: one-cycle ready, done three cycles after the request handshake.
   initial begin
      int wait_n;
      logic [63:0] res;
      wait_n = 0;
      res = '0;
      alu_ready_i = 1'b0;
      alu_done_i = 1'b0;
      alu_result_i = '0;
      forever begin
         @(negedge clk_i);
         alu_done_i = 1'b0;
         if (alu_ready_i) begin
            alu_ready_i = 1'b0;
            wait_n = 3;
         end else if (alu_valid_o) begin
            alu_ready_i = 1'b1;
            reqs.push_back({alu_op_o, alu_a_o, alu_b_o});
            res = alu_op_o == 2'd0 ? 64'(alu_a_o + alu_b_o)
                : alu_op_o == 2'd1 ? 64'(alu_a_o) * 64'(alu_b_o)
                : alu_b_o == 32'd0 ? {alu_a_o, 32'hFFFF_FFFF} : {alu_a_o % alu_b_o, alu_a_o / alu_b_o};
         end else if (wait_n > 0) begin
            wait_n--;
            if (wait_n == 0) begin
               alu_done_i = 1'b1;
               alu_result_i = res;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asr++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk_i);
      rx_data_i = b;
      rx_valid_i = 1'b1;
      while (!rx_ready_o && n < 1000) begin
         @(negedge clk_i);
         n++;
      end
      if (n == 1000) check("rx_ready_wait", 64'(n), 64'd0);
      @(posedge clk_i);
      #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
      send_byte(op);
      send_byte(8'h00);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic expect_tx(input string tag, input int n, input logic [63:0] exp);
      int base;
      base = tx_base;
      for (int i = 0; i < 2000 && txq.size() < base + n; i++) @(negedge clk_i);
      repeat (4) @(negedge clk_i);
      check({tag, "_len"}, 64'(txq.size() - base), 64'(n));
      for (int i = 0; i < n && base + i < txq.size(); i++) check(tag, 64'(txq[base + i]), 64'(exp[8*i +: 8]));
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      tx_base = txq.size();
   endtask

   task automatic expect_req(input string tag, input int idx, input logic [65:0] exp);
      logic [65:0] got;
      got = idx < reqs.size() ? reqs[idx] : '1;
      check({tag, "_op"}, 64'(got[65:64]), 64'(exp[65:64]));
      check({tag, "_ab"}, got[63:0], exp[63:0]);
   endtask

   initial begin
      int r, bad;
      logic [7:0] d0;
      rst_i = 1'b1;
      rx_data_i = '0;
      rx_valid_i = 1'b0;
      tx_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_ctl", 64'({rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o, busy_o}), 64'd0);
      check("rst_ab", {alu_a_o, alu_b_o}, 64'd0);
      check("rst_err", 64'(err_count_o), 64'd0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("idle_ready", 64'(rx_ready_o), 64'd1);

      send_hdr(8'hEC, 16'd7);
      send_byte(8'h41);
      send_byte(8'h42);
      send_byte(8'h43);
      expect_tx("echo", 3, 64'h434241);

      r = reqs.size();
      send_hdr(8'hA0, 16'd12);
      send_word(32'd1);
      send_word(32'd2);
      expect_tx("add", 4, 64'h3);
      check("add_nreq", 64'(reqs.size() - r), 64'd1);
      expect_req("add_req", r, {2'd0, 32'd1, 32'd2});

      r = reqs.size();
      send_hdr(8'hA1, 16'd16);
      send_word(32'd3);
      send_word(32'd4);
      send_word(32'd5);
      expect_tx("mul", 4, 64'h3C);
      check("mul_nreq", 64'(reqs.size() - r), 64'd2);
      expect_req("mul_req0", r, {2'd1, 32'd3, 32'd4});
      expect_req("mul_req1", r + 1, {2'd1, 32'd12, 32'd5});

      r = reqs.size();
      send_hdr(8'hA2, 16'd12);
      send_word(32'd100);
      send_word(32'd7);
      expect_tx("div", 8, 64'h00000002_0000000E);
      expect_req("div_req", r, {2'd2, 32'd100, 32'd7});

      r = reqs.size();
      send_hdr(8'hA2, 16'd8);
      send_word(32'd9);
      expect_tx("div1", 8, 64'h00000009_FFFFFFFF);
      check("div1_nreq", 64'(reqs.size() - r), 64'd0);

      send_hdr(8'hA0, 16'd2);
      expect_tx("short", 4, 64'h0);

      send_hdr(8'hA0, 16'd10);
      send_word(32'd7);
      send_byte(8'hEE);
      send_byte(8'hEE);
      expect_tx("trail", 4, 64'h7);

      send_hdr(8'h55, 16'd6);
      send_byte(8'hAA);
      send_byte(8'hBB);
      expect_tx("unk", 0, 64'h0);
      check("unk_err", 64'(err_count_o), 64'd1);
      send_hdr(8'hA0, 16'd12);
      send_word(32'h10);
      send_word(32'h20);
      expect_tx("recover", 4, 64'h30);

      tx_ready_i = 1'b0;
      send_hdr(8'hA0, 16'd12);
      send_word(32'd1);
      send_word(32'd2);
      for (int i = 0; i < 500 && !tx_valid_o; i++) @(negedge clk_i);
      check("bp_valid", 64'(tx_valid_o), 64'd1);
      d0 = tx_data_o;
      check("bp_data", 64'(d0), 64'h3);
      bad = 0;
      repeat (200) begin
         @(negedge clk_i);
         if (tx_data_o !== d0 || !tx_valid_o || rx_ready_o) bad++;
      end
      check("bp_stable", 64'(bad), 64'd0);
      #2 rst_i = 1'b1;
      #1;
      check("arst_ctl", 64'({rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o, busy_o}), 64'd0);
      check("arst_ab", {alu_a_o, alu_b_o}, 64'd0);
      check("arst_err", 64'(err_count_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tx_ready_i = 1'b1;
      tx_base = txq.size();
      send_hdr(8'hA0, 16'd12);
      send_word(32'h11);
      send_word(32'h22);
      expect_tx("post_rst", 4, 64'h33);

`ifdef ALU_CTRL_TIMEOUT_EN
      send_hdr(8'hA0, 16'd12);
      repeat (50) @(negedge clk_i);
      check("to_wait", 64'(busy_o), 64'd1);
      repeat (60) @(negedge clk_i);
      check("to_idle", 64'(busy_o), 64'd0);
      check("to_err", 64'(err_count_o), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_packet_ctrl.md
# alu_packet_ctrl

Packet-level sequencer between the UART receive/transmit AXI-stream byte ports and the 32-bit ALU inside `uart_mod`. It parses host packets, streams 32-bit little-endian operands into the ALU one operation at a time, and serializes the result back as bytes. Echo packets are forwarded directly from receive to transmit.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle-byte cycles before a partial packet is aborted. Used only with `ALU_CTRL_TIMEOUT_EN`.
- `clk_i` input, 1 bit: single clock domain (16 MHz).
- `rst_i` input, 1 bit: reset, asynchronous, active-high.
- `rx_data_i` input, 8 bits: byte from `uart_rx`.
- `rx_valid_i` input, 1 bit: `rx_data_i` is valid.
- `rx_ready_o` output, 1 bit: block accepts the byte.
- `tx_data_o` output, 8 bits: byte to `uart_tx`.
- `tx_valid_o` output, 1 bit: `tx_data_o` is valid.
- `tx_ready_i` input, 1 bit: `uart_tx` accepts the byte.
- `alu_op_o` output, 2 bits: ADD=0, MUL=1, DIV=2.
- `alu_a_o` output, 32 bits: accumulator or dividend.
- `alu_b_o` output, 32 bits: new operand or divisor.
- `alu_valid_o` output, 1 bit: ALU request.
- `alu_ready_i` input, 1 bit: ALU accepts the request.
- `alu_done_i` input, 1 bit: one-cycle pulse, `alu_result_i` is valid.
- `alu_result_i` input, 64 bits: result. For DIV, {remainder, quotient}. For ADD/MUL, the low 32 bits are used.
- `busy_o` output, 1 bit: state is not IDLE.
- `err_count_o` output, 8 bits: saturating count of dropped packets.

## Operation
- Packet format: opcode, reserved, len_lsb, len_msb, payload.
  - len is the total byte count including the 4-byte header.
  - len < 4 is treated as 4.
  - Payload size is len − 4.
- Opcodes:
  - 0xEC: echo.
  - 0xA0: add; all operands are summed, wrapping mod 2^32.
  - 0xA1: multiply; low 32 bits of the running product are kept.
  - 0xA2: divide. Operands are dividend then divisor. Further operands are drained and ignored. Divide-by-zero results come from the ALU unmodified.
- Any other opcode: payload is drained, no response is sent, and `err_count_o` increments (saturates at 255).
- States: IDLE, HDR_RSV, HDR_LSB, HDR_MSB, ECHO, OPND, ALU_REQ, ALU_WAIT, DRAIN, RESP.
- Header path: IDLE→HDR_RSV→HDR_LSB→HDR_MSB. Each transition happens on a byte handshake.
- From HDR_MSB, the next state depends on opcode and payload:
  - Payload 0, echo or unknown opcode: IDLE.
  - Payload 0, math opcode: RESP with result 0.
  - Echo: ECHO.
  - Math opcode: OPND.
  - Unknown opcode: DRAIN.
- ECHO:
  - One-entry buffer; `rx_ready_o` = !`tx_valid_o` || `tx_ready_i`.
  - Returns to IDLE after the last payload byte is handed off on tx.
- OPND:
  - Shifts 4 bytes into the operand register, LSB first.
  - First operand loads the accumulator directly; there is no ALU op.
  - Each later operand (2nd for DIV) goes to ALU_REQ.
- ALU_REQ: holds `alu_valid_o` until `alu_ready_i`, then goes to ALU_WAIT.
- ALU_WAIT: on `alu_done_i`, the accumulator takes the result (DIV keeps all 64 bits).
  - Returns to OPND if payload remains.
  - Otherwise goes to RESP.
- Trailing payload bytes (payload mod 4) are consumed and discarded before RESP.
  - A single operand yields the operand itself as the result.
  - DIV with fewer than 2 operands yields quotient 0xFFFFFFFF and remainder equal to the dividend (0 if none).
- RESP:
  - Sends 4 bytes for ADD/MUL, or 8 bytes for DIV (quotient then remainder), each LSB first.
  - Returns to IDLE after the last byte is handed off.
- `rx_ready_o` is 0 in ALU_REQ, ALU_WAIT and RESP. The host must not send during a response.

## Timing
- Reset values: all outputs 0; state IDLE; accumulator, length and byte counters cleared. Reset during any state aborts at once; no partial response is sent.
- `rx_ready_o` is registered and is 1 in IDLE, the header states, OPND and DRAIN.
- A byte transfers in a cycle where valid && ready, on both streams.
- `tx_data_o` is held stable while `tx_valid_o` && !`tx_ready_i`.
- In RESP, `tx_valid_o` first asserts one cycle after the RESP entry edge. After each handshake it re-asserts the next cycle with the next byte, with no bubble when `tx_ready_i` stays high.
- `alu_a_o`, `alu_b_o` and `alu_op_o` are stable for the whole time `alu_valid_o` is high.
- ALU latency is arbitrary. `alu_done_i` is ignored outside ALU_WAIT.
- Payload counter is 16 bits. len = 0xFFFF gives 65531 payload bytes with no wrap.
- Echo latency: rx handshake to `tx_valid_o` is 1 cycle.

## Configuration
- `ALU_CTRL_TIMEOUT_EN` defined:
  - A counter resets on every rx handshake and counts in the header states, OPND, DRAIN and ECHO.
  - When it reaches `TIMEOUT_CYCLES`, the state returns to IDLE, `err_count_o` increments, and no response is sent.
  - The counter does not run in IDLE, ALU_REQ, ALU_WAIT or RESP.
- Undefined: there is no counter, and a partial packet waits indefinitely.

## Structure
- `alu_ctrl_pkg`:
  - opcode constants (OP_ECHO=8'hEC, OP_ADD=8'hA0, OP_MUL=8'hA1, OP_DIV=8'hA2).
  - `alu_op_t` enum.
  - `ctrl_state_t` enum.
  - HDR_BYTES=4.
- One sub-module, `alu_ctrl_resp_ser`: loads 64 bits plus a byte count (4 or 8) and emits them LSB-first over a valid/ready byte stream.

## Test plan
- Echo: EC 00 07 00 41 42 43 → tx 41 42 43, then back to IDLE with `busy_o`=0.
- Add: A0 00 0C 00, then operands 1 and 2 → tx 03 00 00 00; one ADD request with a=1, b=2.
- Multiply: A1 00 10 00, then operands 3, 4, 5 → tx 3C 00 00 00, from two MUL requests.
- Divide: A2 00 0C 00, dividend 100, divisor 7 → tx 0E 00 00 00 02 00 00 00.
- Unknown opcode then recovery: 55 00 06 00 AA BB → no tx and `err_count_o`=1. An add packet sent immediately after responds correctly.
- Backpressure and reset: hold `tx_ready_i`=0 for 200 cycles in RESP → `tx_data_o` is stable and `rx_ready_o`=0. Asserting `rst_i` mid-RESP clears all outputs asynchronously. With `ALU_CTRL_TIMEOUT_EN`, header only followed by a stall → IDLE after `TIMEOUT_CYCLES` and `err_count_o`=1.
